// File: rtl/sipo_frame_rx.sv
// Framed serial-in/parallel-out receiver: start, WIDTH data bits (LSB first),
// optional even parity, stop. A good word is presented with a one-cycle load pulse.
module sipo_frame_rx #(
  parameter int WIDTH     = 4,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             sin,
  output logic [WIDTH-1:0] data_out,
  output logic             load,
  output logic             frame_err,
  output logic             parity_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    RESYNC = 3'd4
  } state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic             par_bad, par_bad_nx;
  logic [WIDTH-1:0] data_nx;
  logic             load_nx, frame_err_nx, parity_err_nx;

  // Even parity check: any odd count of ones across data and parity bit is a mismatch.
  function automatic logic parity_mismatch(input logic [WIDTH-1:0] d, input logic p);
    return ^{d, p};
  endfunction

  // State, datapath and registered output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= {CW{1'b0}};
      shreg      <= {WIDTH{1'b0}};
      par_bad    <= 1'b0;
      data_out   <= {WIDTH{1'b0}};
      load       <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      shreg      <= shreg_nx;
      par_bad    <= par_bad_nx;
      data_out   <= data_nx;
      load       <= load_nx;
      frame_err  <= frame_err_nx;
      parity_err <= parity_err_nx;
      busy       <= (state_nx != IDLE);
    end
  end

  // Next-state and next-output logic; everything holds unless a strobe arrives.
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    shreg_nx      = shreg;
    par_bad_nx    = par_bad;
    data_nx       = data_out;
    load_nx       = 1'b0;
    frame_err_nx  = 1'b0;
    parity_err_nx = 1'b0;
    if (bit_en) begin
      case (state)
        IDLE: begin
          if (!sin) begin
            state_nx   = DATA;
            cnt_nx     = {CW{1'b0}};
            par_bad_nx = 1'b0;
          end else begin
            state_nx = IDLE;
          end
        end
        DATA: begin
          shreg_nx = {sin, shreg[WIDTH-1:1]};
          cnt_nx   = cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state_nx = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            state_nx = DATA;
          end
        end
        PARITY: begin
          par_bad_nx = parity_mismatch(shreg, sin);
          state_nx   = STOP;
        end
        STOP: begin
          if (sin) begin
            if (!par_bad) begin
              data_nx = shreg;
              load_nx = 1'b1;
            end else begin
              parity_err_nx = 1'b1;
            end
            state_nx = IDLE;
          end else begin
            frame_err_nx  = 1'b1;
            parity_err_nx = par_bad;
            state_nx      = RESYNC;
          end
        end
        RESYNC: begin
          // A low line here is a broken frame tail, never a start bit.
          if (sin) begin
            state_nx = IDLE;
          end else begin
            state_nx = RESYNC;
          end
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end else begin
      state_nx = state;
    end
  end

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Table-driven bench for sipo_frame_rx: per-edge vectors with hand-computed
// expected outputs, plus a hand-written half-rate strobe sequence.
module tb_sipo_frame_rx;

  logic       clk = 1'b0;
  logic       rst, bit_en, sin;
  logic [3:0] data_out;
  logic       load, frame_err, parity_err, busy;

  int checks   = 0;
  int failures = 0;

  sipo_frame_rx #(.WIDTH(4), .PARITY_EN(1)) dut (
    .clk(clk), .rst(rst), .bit_en(bit_en), .sin(sin),
    .data_out(data_out), .load(load), .frame_err(frame_err),
    .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       e;
    logic       s;
    logic [3:0] d;
    logic       l;
    logic       f;
    logic       p;
    logic       b;
  } vec_t;

  vec_t vq[$];

  task automatic v(input logic r, input logic e, input logic s, input logic [3:0] d,
                   input logic l, input logic f, input logic p, input logic b);
    vec_t x;
    x.r = r; x.e = e; x.s = s; x.d = d; x.l = l; x.f = f; x.p = p; x.b = b;
    vq.push_back(x);
  endtask

  // n non-strobe cycles: outputs quiet, busy as given
  task automatic gap(input int n, input logic s, input logic [3:0] d, input logic b);
    for (int i = 0; i < n; i++) v(1'b0, 1'b0, s, d, 1'b0, 1'b0, 1'b0, b);
  endtask

  // start + 4 data bits LSB first + parity bit; busy high, no pulses, data_out held at d
  task automatic body(input logic [3:0] data, input logic par, input logic [3:0] d);
    v(1'b0, 1'b1, 1'b0, d, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) v(1'b0, 1'b1, data[i], d, 1'b0, 1'b0, 1'b0, 1'b1);
    v(1'b0, 1'b1, par, d, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    logic [6:0] fr;
    rst = 1'b1; bit_en = 1'b0; sin = 1'b1;

    // reset, idle-high, low line without strobe
    v(1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    v(1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    v(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    // good 0110 frame
    body(4'b0110, 1'b0, 4'h0);
    v(1'b0, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0);
    // back-to-back 1010 then 0110
    body(4'b1010, 1'b0, 4'b0110);
    v(1'b0, 1'b1, 1'b1, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0);
    body(4'b0110, 1'b0, 4'b1010);
    v(1'b0, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0);
    // sparse strobe 1010, line toggled during gaps
    v(1'b0, 1'b1, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b1); gap(3, 1'b1, 4'b0110, 1'b1);
    v(1'b0, 1'b1, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b1); gap(3, 1'b1, 4'b0110, 1'b1);
    v(1'b0, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b1); gap(3, 1'b0, 4'b0110, 1'b1);
    v(1'b0, 1'b1, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b1); gap(3, 1'b1, 4'b0110, 1'b1);
    v(1'b0, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b1); gap(3, 1'b0, 4'b0110, 1'b1);
    v(1'b0, 1'b1, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b1); gap(3, 1'b1, 4'b0110, 1'b1);
    v(1'b0, 1'b1, 1'b1, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0); gap(3, 1'b0, 4'b1010, 1'b0);
    // good 0110 then 1010 with bad parity
    body(4'b0110, 1'b0, 4'b1010);
    v(1'b0, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0);
    body(4'b1010, 1'b1, 4'b0110);
    v(1'b0, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0);
    v(1'b0, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
    // frame error, low line held in resync, then a good 1010
    body(4'b0110, 1'b0, 4'b0110);
    v(1'b0, 1'b1, 1'b0, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) v(1'b0, 1'b1, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b1);
    v(1'b0, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
    body(4'b1010, 1'b0, 4'b0110);
    v(1'b0, 1'b1, 1'b1, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0);
    // parity and stop both bad
    body(4'b0110, 1'b1, 4'b1010);
    v(1'b0, 1'b1, 1'b0, 4'b1010, 1'b0, 1'b1, 1'b1, 1'b1);
    v(1'b0, 1'b1, 1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0);
    // reset after two data bits, with a low sample on the same edge
    v(1'b0, 1'b1, 1'b0, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b1);
    v(1'b0, 1'b1, 1'b0, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b1);
    v(1'b0, 1'b1, 1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b1);
    v(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    body(4'b0110, 1'b0, 4'h0);
    v(1'b0, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].r; bit_en = vq[i].e; sin = vq[i].s;
      @(posedge clk); #1;
      chk("data_out", i, data_out, vq[i].d);
      chk("load", i, {3'b000, load}, {3'b000, vq[i].l});
      chk("frame_err", i, {3'b000, frame_err}, {3'b000, vq[i].f});
      chk("parity_err", i, {3'b000, parity_err}, {3'b000, vq[i].p});
      chk("busy", i, {3'b000, busy}, {3'b000, vq[i].b});
    end

    // half-rate strobe, 1010 frame: start, 0,1,0,1, parity 0, stop 1
    rst = 1'b0;
    fr = 7'b1010100;
    for (int i = 0; i < 7; i++) begin
      bit_en = 1'b1; sin = fr[i];
      @(posedge clk); #1;
      if (i < 6) begin
        chk("hs_busy", i, {3'b000, busy}, 4'h1);
        chk("hs_load_early", i, {3'b000, load}, 4'h0);
      end else begin
        chk("hs_load", i, {3'b000, load}, 4'h1);
        chk("hs_data", i, data_out, 4'b1010);
        chk("hs_busy_end", i, {3'b000, busy}, 4'h0);
      end
      bit_en = 1'b0; sin = ~fr[i];
      @(posedge clk); #1;
      if (i == 6) begin
        chk("hs_load_width", i, {3'b000, load}, 4'h0);
        chk("hs_data_hold", i, data_out, 4'b1010);
      end else begin
        chk("hs_gap_busy", i, {3'b000, busy}, 4'h1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
